// File: rtl/relu_pkg.sv
// Shared constants and state encoding for the RELU lane arbiter.
package relu_pkg;

  localparam int NREQ_DEF     = 4;
  localparam int DW_DEF       = 32;
  localparam int CNT_W_DEF    = 10;
  localparam int RELU_LAT_DEF = 1;
  localparam int LANE_W_DEF   = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } relu_state_e;

  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: lowest requesting index at or after ptr wins, wrapping.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             enable,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  int               lane;
  logic [IDX_W-1:0] lane_idx;
  logic             found;

  always_comb begin
    gnt      = '0;
    idx      = '0;
    lane     = 0;
    lane_idx = '0;
    found    = 1'b0;
    if (enable) begin
      for (int k = 0; k < NREQ; k++) begin
        lane     = (int'(ptr) + k) % NREQ;
        lane_idx = IDX_W'(lane);
        if (!found && req[lane_idx]) begin
          found         = 1'b1;
          gnt[lane_idx] = 1'b1;
          idx           = lane_idx;
        end
      end
    end
  end

endmodule

// File: rtl/relu_arbiter.sv
// Shares one RELU unit among NREQ neuron lanes for a layer of layer_len operands,
// routing each result back to its owning lane via a tag pipe matched to RELU latency.
module relu_arbiter
  import relu_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int DW       = DW_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int RELU_LAT = RELU_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   layer_len,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [DW-1:0]      relu_a_in,
  output logic               relu_a_val,
  input  logic [DW-1:0]      relu_y_out,
  input  logic               relu_y_val,
  output logic [DW-1:0]      res_data,
  output logic [NREQ-1:0]    res_val,
  output logic               busy,
  output logic               layer_done,
  output logic               err
);

  localparam int IDX_W = lane_w(NREQ);

  relu_state_e      state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] len_q, issued, retired;

  logic [NREQ-1:0]  gnt_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [DW-1:0]    data_p0;
  logic             xfer_p0, last_issue_p0;

  logic             vld_p1;
  logic [IDX_W-1:0] tag_p1;
  logic [DW-1:0]    data_p1;

  logic             tag_vld_sr [RELU_LAT];
  logic [IDX_W-1:0] tag_sr     [RELU_LAT];
  logic             retire, orphan, last_retire;

  function automatic logic [NREQ-1:0] lane_onehot(input logic [IDX_W-1:0] i);
    lane_onehot    = '0;
    lane_onehot[i] = 1'b1;
  endfunction

  // p0: arbitration and operand select
  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
    .req    (req),
    .ptr    (ptr),
    .enable (state == ST_RUN),
    .gnt    (gnt_p0),
    .idx    (idx_p0)
  );

  assign gnt           = gnt_p0;
  assign xfer_p0       = |(req & gnt_p0);
  assign data_p0       = req_data[int'(idx_p0)*DW +: DW];
  assign last_issue_p0 = xfer_p0 && ((issued + 1'b1) == len_q);

  // A result only counts when the tag pipe says an operand is due now.
  assign retire      = relu_y_val && tag_vld_sr[RELU_LAT-1];
  assign orphan      = relu_y_val && !tag_vld_sr[RELU_LAT-1];
  assign last_retire = retire && ((retired + 1'b1) == len_q);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (layer_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (last_issue_p0) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_retire) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy       = (state != ST_IDLE);
  assign relu_a_val = vld_p1;
  assign relu_a_in  = data_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      len_q      <= '0;
      issued     <= '0;
      retired    <= '0;
      vld_p1     <= 1'b0;
      tag_p1     <= '0;
      data_p1    <= '0;
      res_val    <= '0;
      res_data   <= '0;
      layer_done <= 1'b0;
      err        <= 1'b0;
      for (int k = 0; k < RELU_LAT; k++) begin
        tag_vld_sr[k] <= 1'b0;
        tag_sr[k]     <= '0;
      end
    end else begin
      state      <= state_nxt;
      layer_done <= (state == ST_DONE);
      err        <= err | orphan;

      if (state == ST_IDLE && start) begin
        len_q   <= layer_len;
        issued  <= '0;
        retired <= '0;
      end else begin
        if (xfer_p0 && issued != len_q) issued <= issued + 1'b1;
        if (retire && retired != len_q) retired <= retired + 1'b1;
      end

      if (xfer_p0) ptr <= (int'(idx_p0) == NREQ-1) ? '0 : idx_p0 + 1'b1;

      // p1: operand register toward the RELU
      vld_p1 <= xfer_p0;
      if (xfer_p0) begin
        tag_p1  <= idx_p0;
        data_p1 <= data_p0;
      end

      tag_vld_sr[0] <= vld_p1;
      tag_sr[0]     <= tag_p1;
      for (int k = 1; k < RELU_LAT; k++) begin
        tag_vld_sr[k] <= tag_vld_sr[k-1];
        tag_sr[k]     <= tag_sr[k-1];
      end

      // p2: result broadcast with owner one-hot
      res_val <= retire ? lane_onehot(tag_sr[RELU_LAT-1]) : '0;
      if (retire) res_data <= relu_y_out;
    end
  end

endmodule

// File: doc/relu_arbiter.md
RELU_ARBITER -- requirements
Module: relu_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of requesting neuron lanes sharing one RELU unit.
REQ-002 Parameter DW, 32, IEEE-754 single data width.
REQ-003 Parameter CNT_W, 10, width of layer length and result counters.
REQ-004 Parameter RELU_LAT, 1, RELU a_val-to-y_val latency in cycles.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 start  in  1  one-cycle pulse; begins a layer.
REQ-008 layer_len  in  CNT_W  results expected this layer; sampled on accepted start.
REQ-009 req  in  NREQ  per-lane operand valid.
REQ-010 req_data  in  NREQ*DW  packed operands; lane i at bits [i*DW +: DW].
REQ-011 gnt  out  NREQ  one-hot, combinational; transfer occurs when req[i]&gnt[i].
REQ-012 relu_a_in  out  DW  registered operand to RELU.
REQ-013 relu_a_val  out  1  registered operand valid to RELU.
REQ-014 relu_y_out  in  DW  RELU result.
REQ-015 relu_y_val  in  1  RELU result valid.
REQ-016 res_data  out  DW  registered result broadcast to all lanes.
REQ-017 res_val  out  NREQ  registered one-hot; marks owning lane of res_data.
REQ-018 busy  out  1  high in any state except IDLE.
REQ-019 layer_done  out  1  one-cycle pulse when all layer_len results are returned.
REQ-020 err  out  1  sticky; relu_y_val with no outstanding tag.

Function
REQ-021 FSM states IDLE, RUN, DRAIN, DONE.
REQ-022 IDLE: gnt=0; start -> RUN, latch layer_len, clear issued/retired counters; start with layer_len=0 -> DONE.
REQ-023 start outside IDLE ignored, no state change.
REQ-024 RUN: at most one grant per cycle, round-robin from pointer ptr; lowest index >= ptr (wrapping) with req high wins.
REQ-025 After a grant to lane i, ptr <= (i+1) mod NREQ; ptr unchanged when no grant.
REQ-026 Granted transfer: next cycle relu_a_val=1, relu_a_in=lane data; issued increments; relu_a_val=0 in cycles without transfer.
REQ-027 Grant whose increment makes issued==layer_len -> DRAIN next cycle; no grants in DRAIN, DONE or IDLE.
REQ-028 Lane tag travels a RELU_LAT-deep shift register aligned with relu_a_val.
REQ-029 On relu_y_val: next cycle res_data=relu_y_out, res_val=onehot(tag), retired increments; otherwise res_val=0.
REQ-030 DRAIN -> DONE in the cycle retired reaches layer_len; DONE asserts layer_done one cycle, then -> IDLE.
REQ-031 relu_y_val with empty tag pipe: result dropped, err set, counters unchanged.
REQ-032 Issue and retire in the same cycle both count; counters never wrap (bounded by layer_len).
REQ-033 End-to-end latency grant -> res_val = RELU_LAT+2 cycles; throughput one result per cycle.

Reset
REQ-034 rst_n low: state IDLE, ptr=0, counters 0, tag pipe empty, all outputs 0, err cleared.
REQ-035 Reset mid-layer discards in-flight operands; no res_val or layer_done produced for them.

Structure
REQ-036 Package relu_pkg holds the state enum, NREQ/DW/CNT_W/RELU_LAT defaults, and lane-index width constant.
REQ-037 Sub-module rr_arbiter (req, ptr, enable -> one-hot gnt, granted index) is instantiated once.

Verification
REQ-038 layer_len=4, req=4'b1111 held, ptr=0 -> gnts lanes 0,1,2,3 in consecutive cycles; layer_done 1 cycle after 4th res_val.
REQ-039 Lane 2 operand 0xC0400000 (-3.0) -> res_val=4'b0100, res_data=0x00000000; operand 0x40400000 -> res_data=0x40400000.
REQ-040 layer_len=0 with start -> layer_done 2 cycles later, relu_a_val never asserted.
REQ-041 layer_len=3, req=4'b1111 -> exactly 3 grants, 4th lane never granted, gnt=0 during DRAIN.
REQ-042 rst_n low for 1 cycle with 1 operand in flight -> no res_val, busy=0, next start behaves as fresh layer.
REQ-043 relu_y_val pulse forced in IDLE -> err=1 and stays 1 until reset; res_val stays 0.
